perow_loader: RTL and testbench
===============================

// Module: perow_loader
// PURPOSE
//  Write-side companion to the PE row buffer. Accepts a word stream from the
//  host/DMA over a valid/ready handshake and fills NROWS row buffers in
//  row-major order, driving per-row write strobes, a shared write address and
//  write data. A load that ends early is zero-padded, so every row buffer holds
//  exactly BUFSIZE words before the array starts reading.
// PARAMETERS
//  WORDLEN  8  data word width in bits
//  BUFSIZE  8  words per row buffer (>=2)
//  NROWS    4  number of PE row buffers fed (>=1)
//  AW       $clog2(BUFSIZE)  local, write address width
// PORTS
//  clk         in   1        system clock, rising edge
//  rstn        in   1        asynchronous active-low reset
//  start       in   1        one-cycle pulse: begin a new load (IDLE only)
//  in_valid    in   1        upstream word valid
//  in_ready    out  1        loader can accept a word this cycle
//  in_dat      in   WORDLEN  upstream word
//  in_last     in   1        qualifies in_dat as the final word of the load
//  wr_en       out  NROWS    one-hot row write strobe (registered)
//  wr_addr     out  AW       word index within the row (registered)
//  wr_dat      out  WORDLEN  write data (registered)
//  busy        out  1        high in LOAD or PAD
//  done        out  1        one-cycle pulse: all NROWS*BUFSIZE entries written
//  short_load  out  1        sticky: last load ended early and was padded
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, row/word counters=0, wr_en=0,
//   wr_addr=0, wr_dat=0, in_ready=0, busy=0, done=0, short_load=0.
//  FSM IDLE -> LOAD -> (PAD) -> IDLE:
//   IDLE: in_ready=0. start=1 -> clear counters and short_load, go LOAD.
//   LOAD: in_ready=1 (combinational from state). Accept = in_valid&in_ready.
//    Each accepted word: next cycle wr_en[row]=1, wr_addr=word, wr_dat=in_dat.
//    word increments; at BUFSIZE-1 it wraps to 0 and row increments.
//    Accepting entry (NROWS-1, BUFSIZE-1) -> IDLE; in_last is ignored there.
//    in_last on any earlier entry -> PAD; short_load set with that final write.
//   PAD: in_ready=0. Writes 0 to every remaining entry, one per cycle, same
//    ordering and counters; after entry (NROWS-1, BUFSIZE-1) -> IDLE.
//  Latency: handshake at cycle N -> wr_en at cycle N+1. No bubbles: with
//   in_valid held high, NROWS*BUFSIZE consecutive write cycles.
//  done: high exactly in the cycle that carries the final wr_en
//   (row NROWS-1, addr BUFSIZE-1), for both full and padded loads.
//  wr_en is 0 in any cycle with no write; wr_addr/wr_dat hold their last value.
//  start is ignored in LOAD/PAD. in_valid in IDLE is not accepted.
//  Words with in_valid=0 create gaps; counters advance only on accept.
//  Reset mid-load: all state returns to reset values immediately; the partial
//   load is abandoned and no done pulse is issued.
// TESTING
//  T1 NROWS=4,BUFSIZE=8: start, 32 words 0x01..0x20, in_valid constant ->
//     32 contiguous wr_en cycles; row0 addr0..7 = 0x01..0x08, row3 addr7 =
//     0x20; done coincides with that write; short_load=0.
//  T2 Random in_valid gaps (~50%) on same data -> identical write sequence,
//     wr_en=0 in gap cycles, done exactly once.
//  T3 in_last on 10th word (row1, addr1) -> in_ready drops after it; 22 zero
//     writes row1 addr2 .. row3 addr7; done on the last; short_load=1 until
//     next start.
//  T4 start pulsed mid-LOAD and in_valid held high in IDLE -> no counter
//     reset, no write from IDLE, and in_ready=0 in IDLE.
//  T5 rstn low after 5 accepted words -> all outputs 0 asynchronously; new
//     start writes row0 addr0 first.
//  T6 in_last together with word 32 -> normal completion, no PAD cycles,
//     short_load=0.

Source files
------------

// File: rtl/perow_loader.sv
// Fills NROWS row buffers row-major from a valid/ready word stream, zero-padding short loads.
// Latency: accepted word appears on wr_en/wr_addr/wr_dat one cycle after the handshake.
// Backpressure: in_ready is high only in LOAD; no bubbles while in_valid stays high.
module perow_loader #(
    parameter int WORDLEN = 8,
    parameter int BUFSIZE = 8,
    parameter int NROWS   = 4,
    localparam int AW     = $clog2(BUFSIZE)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORDLEN-1:0] in_dat,
    input  logic               in_last,
    output logic [NROWS-1:0]   wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [WORDLEN-1:0] wr_dat,
    output logic               busy,
    output logic               done,
    output logic               short_load
);

    localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam logic [AW-1:0]    WLAST = AW'(BUFSIZE - 1);
    localparam logic [RW-1:0]    RLAST = RW'(NROWS - 1);
    localparam logic [NROWS-1:0] ROW0  = NROWS'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] row;
    logic [AW-1:0] word;
    logic          accept;
    logic          wr_fire;
    logic          last_entry;

    assign last_entry = (row == RLAST) && (word == WLAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // in_last on the final entry is a normal completion, never a pad.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    if (last_entry)   state_nxt = S_IDLE;
                    else if (in_last) state_nxt = S_PAD;
                end
            end
            S_PAD:  if (last_entry) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_LOAD);
        busy     = (state != S_IDLE);
        accept   = in_valid && in_ready;
        wr_fire  = accept || (state == S_PAD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row        <= '0;
            word       <= '0;
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_dat     <= '0;
            done       <= 1'b0;
            short_load <= 1'b0;
        end else begin
            wr_en <= '0;
            done  <= 1'b0;
            if ((state == S_IDLE) && start) begin
                row        <= '0;
                word       <= '0;
                short_load <= 1'b0;
            end
            if (wr_fire) begin
                wr_en   <= ROW0 << row;
                wr_addr <= word;
                wr_dat  <= accept ? in_dat : '0;
                done    <= last_entry;
                if (last_entry) begin
                    row  <= '0;
                    word <= '0;
                end else if (word == WLAST) begin
                    word <= '0;
                    row  <= row + RW'(1);
                end else begin
                    word <= word + AW'(1);
                end
                if (accept && in_last && !last_entry) short_load <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_perow_loader.sv
// Scoreboard bench for perow_loader: driver pushes expected writes, negedge monitor pops and compares.
module tb_perow_loader;

    localparam int WORDLEN = 8;
    localparam int BUFSIZE = 8;
    localparam int NROWS   = 4;
    localparam int NENT    = NROWS * BUFSIZE;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_dat;
    logic         in_last;
    logic [3:0]   wr_en;
    logic [2:0]   wr_addr;
    logic [7:0]   wr_dat;
    logic         busy;
    logic         done;
    logic         short_load;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int run_len = 0;
    int run_at_done = 0;
    logic [15:0] exp_q[$];

    perow_loader #(.WORDLEN(WORDLEN), .BUFSIZE(BUFSIZE), .NROWS(NROWS)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_dat(in_dat), .in_last(in_last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
        .busy(busy), .done(done), .short_load(short_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected write for linear entry k: {one-hot row, addr, data, done}
    function automatic logic [15:0] entry(input int k, input logic [7:0] d);
        logic [3:0] en;
        logic [2:0] a;
        en = 4'b0001 << (k / BUFSIZE);
        a  = 3'(k % BUFSIZE);
        return {en, a, d, (k == NENT - 1)};
    endfunction

    always @(negedge clk) begin
        if (wr_en != '0) begin
            run_len++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {16'h0, wr_en, wr_addr, wr_dat, done}, 32'h0);
            end else begin
                chk("write", {16'h0, wr_en, wr_addr, wr_dat, done}, {16'h0, exp_q.pop_front()});
            end
        end else begin
            run_len = 0;
            if (done) chk("done_without_write", 32'(done), 32'h0);
        end
        if (done) begin
            done_cnt++;
            run_at_done = run_len;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input bit l, input bit exp_wr);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_dat   = d;
        in_last  = l;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && exp_wr) exp_q.push_back(entry(k, d));
            @(posedge clk); #1;
            n++;
        end
        chk("handshake", 32'(acc), 32'h1);
    endtask

    task automatic load(input bit gaps, input int last_idx, input bit mid_start);
        for (int k = 0; k < NENT; k++) begin
            if (gaps) gap($urandom_range(0, 1));
            send(k, 8'(k + 1), (k == last_idx), 1'b1);
            if (mid_start && k == 4) begin
                in_valid = 1'b0;
                pulse_start();
                chk("busy_after_mid_start", 32'(busy), 32'h1);
            end
            if (k == last_idx) begin
                for (int p = k + 1; p < NENT; p++) exp_q.push_back(entry(p, 8'h00));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_load(input string name, input int base);
        int n = 0;
        while (done_cnt == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_done_count"}, 32'(done_cnt - base), 32'h1);
        chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
        chk({name, "_busy_after"}, 32'(busy), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_dat = '0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_dat", 32'(wr_dat), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_short_load", 32'(short_load), 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // T1: continuous full load
        base = done_cnt;
        pulse_start();
        load(1'b0, NENT + 5, 1'b0);
        finish_load("t1", base);
        chk("t1_contiguous_run", 32'(run_at_done), 32'(NENT));
        chk("t1_short_load", 32'(short_load), 32'h0);

        // T2: random gaps
        base = done_cnt;
        pulse_start();
        load(1'b1, NENT + 5, 1'b0);
        finish_load("t2", base);
        chk("t2_short_load", 32'(short_load), 32'h0);

        // T3: early in_last on 10th word, then pad
        base = done_cnt;
        pulse_start();
        load(1'b0, 9, 1'b0);
        @(negedge clk);
        chk("t3_ready_in_pad", 32'(in_ready), 32'h0);
        finish_load("t3", base);
        chk("t3_contiguous_run", 32'(run_at_done), 32'(NENT));
        chk("t3_short_load", 32'(short_load), 32'h1);

        // T4: valid in IDLE ignored, start mid-LOAD ignored
        in_valid = 1'b1; in_dat = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_idle_ready", 32'(in_ready), 32'h0);
            @(posedge clk); #1;
        end
        chk("t4_short_load_sticky", 32'(short_load), 32'h1);
        in_valid = 1'b0;
        base = done_cnt;
        pulse_start();
        chk("t4_short_load_cleared", 32'(short_load), 32'h0);
        load(1'b0, NENT + 5, 1'b1);
        finish_load("t4", base);

        // T5: async reset mid-load, then full reload
        base = done_cnt;
        pulse_start();
        for (int k = 0; k < 4; k++) send(k, 8'(k + 1), 1'b0, 1'b1);
        send(4, 8'h05, 1'b0, 1'b0);
        chk("t5_pre_reset_addr", 32'(wr_addr), 32'h4);
        chk("t5_pre_reset_dat", 32'(wr_dat), 32'h5);
        #2;
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_async_wr_en", 32'(wr_en), 32'h0);
        chk("t5_async_wr_addr", 32'(wr_addr), 32'h0);
        chk("t5_async_wr_dat", 32'(wr_dat), 32'h0);
        chk("t5_async_busy", 32'(busy), 32'h0);
        chk("t5_async_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("t5_no_done_on_abort", 32'(done_cnt - base), 32'h0);
        pulse_start();
        load(1'b0, NENT + 5, 1'b0);
        finish_load("t5", base);

        // T6: in_last coincides with final word
        base = done_cnt;
        pulse_start();
        load(1'b0, NENT - 1, 1'b0);
        finish_load("t6", base);
        chk("t6_contiguous_run", 32'(run_at_done), 32'(NENT));
        chk("t6_short_load", 32'(short_load), 32'h0);
        chk("t6_ready_idle", 32'(in_ready), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
